// File: rtl/reg_file.sv
// 16 x 16-bit register file: combinational read and accumulator ports, one general write port, and a dedicated iszero write port.
// R0 reads as zero. Defining REG_FILE_DBG_EN adds an independent combinational debug read port (dbg_ra/dbg_data).
module reg_file #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int ACC_IDX    = 1,
    parameter int ISZERO_IDX = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] iszero_data,
    input  logic              iszero_write,
`ifdef REG_FILE_DBG_EN
    input  logic [ADDR_W-1:0] dbg_ra,
    output logic [DATA_W-1:0] dbg_data,
`endif
    output logic [DATA_W-1:0] acc_data,
    output logic [DATA_W-1:0] read_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ISZERO_A = ADDR_W'(ISZERO_IDX);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // Next-state: the general port can never reach R0 or the iszero register, so both writes can land together.
    always_comb begin
        regs_d = regs_q;
        if (reg_write && (wa != ZERO_A) && (wa != ISZERO_A)) begin
            regs_d[wa] = write_data;
        end else begin
            regs_d[ISZERO_IDX] = regs_q[ISZERO_IDX];
        end
        if (iszero_write) begin
            regs_d[ISZERO_IDX] = iszero_data;
        end else begin
            regs_d[0] = {DATA_W{1'b0}};
        end
        regs_d[0] = {DATA_W{1'b0}};
    end

    // Storage; reset overrides any write pending on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports straight from stored state.
    always_comb begin
        read_data = (ra == ZERO_A) ? {DATA_W{1'b0}} : regs_q[ra];
        acc_data  = regs_q[ACC_IDX];
    end

`ifdef REG_FILE_DBG_EN
    // Independent debug read port with the same R0 rule.
    always_comb begin
        dbg_data = (dbg_ra == ZERO_A) ? {DATA_W{1'b0}} : regs_q[dbg_ra];
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against an array-based reference model.
module tb_reg_file;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  ra;
    logic [3:0]  wa;
    logic [15:0] write_data;
    logic        reg_write;
    logic [15:0] iszero_data;
    logic        iszero_write;
    logic [15:0] acc_data;
    logic [15:0] read_data;
`ifdef REG_FILE_DBG_EN
    logic [3:0]  dbg_ra;
    logic [15:0] dbg_data;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] model [16];

    always #5 clock = ~clock;

    reg_file dut (
        .clock        (clock),
        .reset        (reset),
        .ra           (ra),
        .wa           (wa),
        .write_data   (write_data),
        .reg_write    (reg_write),
        .iszero_data  (iszero_data),
        .iszero_write (iszero_write),
`ifdef REG_FILE_DBG_EN
        .dbg_ra       (dbg_ra),
        .dbg_data     (dbg_data),
`endif
        .acc_data     (acc_data),
        .read_data    (read_data)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    endtask

    // Entered 1 time unit after a rising edge; leaves 1 time unit after the next one.
    task automatic cycle(input logic [3:0] w_a, input logic [15:0] w_d, input logic w_e,
                         input logic [15:0] z_d, input logic z_e, input logic [3:0] r_a);
        wa = w_a; write_data = w_d; reg_write = w_e;
        iszero_data = z_d; iszero_write = z_e; ra = r_a;
`ifdef REG_FILE_DBG_EN
        dbg_ra = 4'(r_a + 4'd1);
`endif
        #1;
        check_eq("pre_edge_read", read_data, model[r_a]);
        @(posedge clock);
        #1;
        if (!reset) begin
            if (w_e && w_a != 4'd0 && w_a != 4'd3) model[w_a] = w_d;
            if (z_e) model[3] = z_d;
        end
        check_eq("read", read_data, model[r_a]);
        check_eq("acc", acc_data, model[1]);
`ifdef REG_FILE_DBG_EN
        check_eq("dbg", dbg_data, model[4'(r_a + 4'd1)]);
`endif
        reg_write = 1'b0;
        iszero_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ra = 4'd0; wa = 4'd0; write_data = 16'h0000; reg_write = 1'b0;
        iszero_data = 16'h0000; iszero_write = 1'b0;
`ifdef REG_FILE_DBG_EN
        dbg_ra = 4'd0;
`endif
        clear_model();

        // Reset sweep
        for (int a = 0; a < 16; a++) begin
            ra = 4'(a);
            #1;
            check_eq("reset_read", read_data, 16'h0000);
        end
        check_eq("reset_acc", acc_data, 16'h0000);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // General write sweep
        for (int a = 0; a < 15; a++) begin
            cycle(4'(a), 16'hABCD, 1'b1, 16'h0000, 1'b0, 4'(a));
            if (a == 0 || a == 3) check_eq("sweep_protected", read_data, 16'h0000);
            else check_eq("sweep_written", read_data, 16'hABCD);
        end

        // Accumulator
        cycle(4'd1, 16'h1234, 1'b1, 16'h0000, 1'b0, 4'd1);
        check_eq("acc_write", acc_data, 16'h1234);
        cycle(4'd2, 16'h7777, 1'b1, 16'h0000, 1'b0, 4'd2);
        check_eq("acc_unchanged", acc_data, 16'h1234);

        // iszero port and its protection from the general port
        cycle(4'd0, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 4'd3);
        check_eq("iszero_write", read_data, 16'hFFFF);
        cycle(4'd3, 16'hABCD, 1'b1, 16'h0000, 1'b0, 4'd3);
        check_eq("iszero_protect", read_data, 16'hFFFF);

        // Simultaneous writes
        cycle(4'd5, 16'h5555, 1'b1, 16'h0001, 1'b1, 4'd5);
        check_eq("simul_r5", read_data, 16'h5555);
        ra = 4'd3; #1;
        check_eq("simul_r3", read_data, 16'h0001);
        @(posedge clock); #1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle(4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom),
                  16'($urandom), 1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
        end

        // Async reset mid-cycle, then a write attempted under reset
        cycle(4'd1, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 4'd1);
        ra = 4'd1;
        reset = 1'b1;
        #1;
        check_eq("async_reset_read", read_data, 16'h0000);
        check_eq("async_reset_acc", acc_data, 16'h0000);
        clear_model();
        cycle(4'd5, 16'h9999, 1'b1, 16'h4444, 1'b1, 4'd5);
        check_eq("write_in_reset", read_data, 16'h0000);
        ra = 4'd3; #1;
        check_eq("iszero_in_reset", read_data, 16'h0000);
        reset = 1'b0;
        @(posedge clock); #1;
        cycle(4'd7, 16'h0707, 1'b1, 16'h0000, 1'b0, 4'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 16-entry x 16-bit register file for the multi-register accumulator datapath.
- One combinational read port, one synchronous general write port, and a dedicated accumulator output.
- R0 is hardwired zero.
- R3 is the "iszero" status register. It is writable only through its dedicated write port, never through the general write port.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width; depth = 2**ADDR_W = 16.
- ACC_IDX, 1, index of the accumulator register driven on acc_data.
- ISZERO_IDX, 3, index of the iszero status register.

Ports:
- clock  in  1  system clock; all writes on rising edge.
- reset  in  1  asynchronous, active-high; clears all registers.
- ra  in  ADDR_W  read address.
- wa  in  ADDR_W  general write address.
- write_data  in  DATA_W  general write data.
- reg_write  in  1  general write enable.
- iszero_data  in  DATA_W  data for the iszero register.
- iszero_write  in  1  iszero register write enable.
- acc_data  out  DATA_W  current contents of R[ACC_IDX], combinational.
- read_data  out  DATA_W  contents of R[ra], combinational.

Behaviour:
- Reset: while reset=1, all 16 registers are forced to 0, asynchronously. read_data and acc_data therefore read 0. No writes take effect during reset.
- Read path: read_data = R[ra] with zero-cycle latency. It follows ra and register contents combinationally.
- ra=0 always returns 0.
- A write is visible on read_data immediately after the clock edge that performs it. There is no extra cycle of latency.
- General write: at posedge clock, if reg_write=1 then R[wa] <= write_data, except for:
  - wa=0: the write is ignored; R0 stays 0.
  - wa=ISZERO_IDX: the write is ignored; R3 is unchanged.
- iszero write: at posedge clock, if iszero_write=1 then R[ISZERO_IDX] <= iszero_data. This is independent of reg_write and wa.
- Simultaneous writes: reg_write and iszero_write may both be 1 in the same cycle. Both take effect, because they can never target the same register.
- acc_data = R[ACC_IDX] at all times, combinational. It is updated the same edge R1 is written.
- No read-during-write hazard: reads are combinational from stored state, so read_data shows the old value before the edge and the new value after it.
- Reset asserted mid-cycle overrides any pending write. Deassertion is not synchronised inside this block.

Optional Feature:
- Macro REG_FILE_DBG_EN.
- When defined:
  - Adds input dbg_ra [ADDR_W] and output dbg_data [DATA_W].
  - dbg_data = R[dbg_ra], combinational, with the same zero rules as read_data.
  - This is a second independent read port for debug/trace.
- When undefined: the ports do not exist and no extra logic is present.

Test Plan:
- Reset then read: assert reset, sweep ra 0..15 -> read_data=16'h0000 for every address; acc_data=16'h0000.
- General write sweep: for ra=wa=0..14, pulse reg_write with write_data=16'hABCD for one rising edge -> read_data=16'hABCD afterwards for all addresses except 0 and 3, which must not read 16'hABCD (both read 16'h0000).
- Accumulator: write 16'h1234 to wa=1 -> acc_data=16'h1234 after that edge; write to wa=2 -> acc_data unchanged.
- iszero port: iszero_data=16'hFFFF, iszero_write=1 for one edge -> with ra=3, read_data=16'hFFFF. A subsequent reg_write to wa=3 with 16'hABCD leaves read_data at 16'hFFFF.
- Simultaneous writes: same edge, reg_write wa=5 data 16'h5555 and iszero_write data 16'h0001 -> R5=16'h5555, R3=16'h0001.
- Async reset mid-operation: load several registers, assert reset between clock edges -> read_data and acc_data drop to 0 without a clock edge. A write requested while reset=1 has no effect.
